// File: rtl/microcode_sequencer.sv
// Microcode sequencer: steps T0..T5 and decodes ireg[7:4] into the control word.
// Build option SEQ_EARLY_END_EN: return to T0 right after an instruction's last non-empty step.
module microcode_sequencer #(
    parameter int CONTROL_SIGNALS = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 ireg,
    input  logic                       zf,
    input  logic                       cf,
    output logic [CONTROL_SIGNALS-1:0] ctrl,
    output logic [2:0]                 tstate,
    output logic                       halted
);
    localparam logic [14:0] C_HLT = 15'h0001;
    localparam logic [14:0] C_MAI = 15'h0002;
    localparam logic [14:0] C_MI  = 15'h0004;
    localparam logic [14:0] C_MO  = 15'h0008;
    localparam logic [14:0] C_II  = 15'h0010;
    localparam logic [14:0] C_AI  = 15'h0020;
    localparam logic [14:0] C_AO  = 15'h0040;
    localparam logic [14:0] C_ALO = 15'h0080;
    localparam logic [14:0] C_ALS = 15'h0100;
    localparam logic [14:0] C_BI  = 15'h0200;
    localparam logic [14:0] C_OUI = 15'h0800;
    localparam logic [14:0] C_PCS = 15'h1000;
    localparam logic [14:0] C_PCO = 15'h2000;
    localparam logic [14:0] C_PCI = 15'h4000;

    typedef enum logic {S_RUN, S_HALT} state_t;

    state_t      state;
    logic        taken_q;
    logic [3:0]  opcode;
    logic        jmp_cond;
    logic        step_last;
    logic [14:0] word;
    logic        unused_ireg;

    assign opcode      = ireg[7:4];
    assign unused_ireg = ^ireg[3:0];

    function automatic logic [14:0] decode(input logic [3:0] op, input logic [2:0] t,
                                           input logic jc);
        logic [14:0] w;
        w = '0;
        case (t)
            3'd0: w = C_PCO | C_MAI;
            3'd1: w = C_MO | C_II | C_PCS;
            default: begin
                case (op)
                    4'd1, 4'd2, 4'd3, 4'd4: begin
                        case (t)
                            3'd2: w = C_PCO | C_MAI;
                            3'd3: w = C_MO | C_MAI | C_PCS;
                            3'd4: w = (op == 4'd1) ? (C_MO | C_AI) :
                                      (op == 4'd4) ? (C_AO | C_MI) : (C_MO | C_BI);
                            3'd5: w = (op == 4'd2) ? (C_ALO | C_AI) :
                                      (op == 4'd3) ? (C_ALO | C_ALS | C_AI) : '0;
                            default: w = '0;
                        endcase
                    end
                    4'd5: begin
                        if (t == 3'd2) w = C_PCO | C_MAI;
                        else if (t == 3'd3) w = C_MO | C_AI | C_PCS;
                    end
                    4'd6: begin
                        if (t == 3'd2) w = C_PCO | C_MAI;
                        else if (t == 3'd3) w = C_MO | C_PCI;
                    end
                    4'd7, 4'd8: begin
                        // Not-taken branches only step the PC over the operand byte.
                        if (t == 3'd2) w = jc ? (C_PCO | C_MAI) : C_PCS;
                        else if (t == 3'd3 && jc) w = C_MO | C_PCI;
                    end
                    4'd14: if (t == 3'd2) w = C_AO | C_OUI;
                    4'd15: if (t == 3'd2) w = C_HLT;
                    default: w = '0;
                endcase
            end
        endcase
        return w;
    endfunction

`ifdef SEQ_EARLY_END_EN
    function automatic logic [2:0] last_step(input logic [3:0] op, input logic jc);
        case (op)
            4'd1, 4'd4:   return 3'd4;
            4'd2, 4'd3:   return 3'd5;
            4'd5, 4'd6:   return 3'd3;
            4'd7, 4'd8:   return jc ? 3'd3 : 3'd2;
            4'd14, 4'd15: return 3'd2;
            default:      return 3'd1;
        endcase
    endfunction

    assign step_last = (tstate >= last_step(opcode, jmp_cond));
`else
    assign step_last = (tstate == 3'd5);
`endif

    // Branch condition: live flag during T2, the latched decision afterwards.
    always_comb begin
        jmp_cond = taken_q;
        if (tstate == 3'd2)
            jmp_cond = (opcode == 4'd7) ? cf : ((opcode == 4'd8) ? zf : 1'b0);
    end

    always_comb begin
        word = decode(opcode, tstate, jmp_cond);
        if (state == S_HALT) word = C_HLT;
        if (!rst) word = '0;
    end

    assign ctrl = CONTROL_SIGNALS'(word);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_RUN;
            tstate  <= 3'd0;
            taken_q <= 1'b0;
            halted  <= 1'b0;
        end else if (state == S_RUN) begin
            if (tstate == 3'd2) taken_q <= jmp_cond;
            if (tstate == 3'd2 && opcode == 4'd15) begin
                state  <= S_HALT;
                halted <= 1'b1;
            end else if (step_last) begin
                tstate <= 3'd0;
            end else begin
                tstate <= tstate + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: per-instruction step model plus literal spot checks.
module tb_microcode_sequencer;
`ifdef SEQ_EARLY_END_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    localparam logic [14:0] W_HLT = 15'h0001, W_MAI = 15'h0002, W_MI  = 15'h0004;
    localparam logic [14:0] W_MO  = 15'h0008, W_II  = 15'h0010, W_AI  = 15'h0020;
    localparam logic [14:0] W_AO  = 15'h0040, W_ALO = 15'h0080, W_ALS = 15'h0100;
    localparam logic [14:0] W_BI  = 15'h0200, W_OUI = 15'h0800, W_PCS = 15'h1000;
    localparam logic [14:0] W_PCO = 15'h2000, W_PCI = 15'h4000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  ireg = 8'h20;
    logic        zf = 1'b0;
    logic        cf = 1'b0;
    logic [14:0] ctrl;
    logic [2:0]  tstate;
    logic        halted;

    int          errors = 0;
    int          checks = 0;
    logic        chk_en = 1'b0;
    logic [14:0] exp_ctrl = '0;
    logic [2:0]  exp_t = '0;
    logic        exp_h = 1'b0;
    logic [2:0]  max_t = '0;
    logic [14:0] last_ctrl = '0;
    logic [14:0] mq[$];
    logic [14:0] log_q[$];

    microcode_sequencer dut (
        .clk(clk), .rst(rst), .ireg(ireg), .zf(zf), .cf(cf),
        .ctrl(ctrl), .tstate(tstate), .halted(halted)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tstate > max_t) max_t = tstate;
        if (chk_en) begin
            checks++;
            if (ctrl !== exp_ctrl || tstate !== exp_t || halted !== exp_h) begin
                errors++;
                $display("FAIL model_step: ctrl=0x%04h t=%0d halted=%0b, expected ctrl=0x%04h t=%0d halted=%0b",
                         ctrl, tstate, halted, exp_ctrl, exp_t, exp_h);
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Micro-program of one instruction as listed in the instruction table.
    task automatic build_model(input logic [3:0] op, input logic flag);
        mq.delete();
        mq.push_back(W_PCO | W_MAI);
        mq.push_back(W_MO | W_II | W_PCS);
        case (op)
            4'd1: begin mq.push_back(W_PCO | W_MAI); mq.push_back(W_MO | W_MAI | W_PCS); mq.push_back(W_MO | W_AI); end
            4'd2: begin mq.push_back(W_PCO | W_MAI); mq.push_back(W_MO | W_MAI | W_PCS);
                        mq.push_back(W_MO | W_BI); mq.push_back(W_ALO | W_AI); end
            4'd3: begin mq.push_back(W_PCO | W_MAI); mq.push_back(W_MO | W_MAI | W_PCS);
                        mq.push_back(W_MO | W_BI); mq.push_back(W_ALO | W_ALS | W_AI); end
            4'd4: begin mq.push_back(W_PCO | W_MAI); mq.push_back(W_MO | W_MAI | W_PCS); mq.push_back(W_AO | W_MI); end
            4'd5: begin mq.push_back(W_PCO | W_MAI); mq.push_back(W_MO | W_AI | W_PCS); end
            4'd6: begin mq.push_back(W_PCO | W_MAI); mq.push_back(W_MO | W_PCI); end
            4'd7, 4'd8: begin
                if (flag) begin mq.push_back(W_PCO | W_MAI); mq.push_back(W_MO | W_PCI); end
                else mq.push_back(W_PCS);
            end
            4'd14: mq.push_back(W_AO | W_OUI);
            default: ;
        endcase
        if (!EARLY) while (mq.size() < 6) mq.push_back('0);
    endtask

    task automatic step_check(input logic [14:0] e_ctrl, input logic [2:0] e_t, input logic e_h);
        exp_ctrl = e_ctrl;
        exp_t    = e_t;
        exp_h    = e_h;
        chk_en   = 1'b1;
        @(negedge clk);
        last_ctrl = ctrl;
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [7:0] instr, input logic cf0, input logic zf0,
                             input logic cf_late, output int ncyc);
        logic [3:0] op;
        op   = instr[7:4];
        ireg = instr;
        cf   = cf0;
        zf   = zf0;
        build_model(op, (op == 4'd7) ? cf0 : ((op == 4'd8) ? zf0 : 1'b0));
        log_q.delete();
        ncyc = mq.size();
        for (int k = 0; k < mq.size(); k++) begin
            step_check(mq[k], 3'(k), 1'b0);
            log_q.push_back(last_ctrl);
            if (k == 2) cf = cf_late;
        end
        chk("wrap_to_t0", 16'(tstate), 16'd0);
    endtask

    initial begin
        int n;
        int total;
        logic [14:0] tail;

        // Reset held low with a live opcode: outputs must stay forced.
        #8;
        chk("reset_tstate", 16'(tstate), 16'd0);
        chk("reset_ctrl", 16'(ctrl), 16'd0);
        chk("reset_halted", 16'(halted), 16'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        run_instr(8'h00, 1'b0, 1'b0, 1'b0, n);
        chk("nop_cycles", 16'(n), EARLY ? 16'd2 : 16'd6);

        run_instr(8'h1F, 1'b0, 1'b0, 1'b0, n);
        chk("lda_t4", 16'(log_q[4]), 16'h0028);

        run_instr(8'h20, 1'b0, 1'b0, 1'b0, n);
        chk("add_t0", 16'(log_q[0]), 16'h2002);
        chk("add_t1", 16'(log_q[1]), 16'h1018);
        chk("add_t2", 16'(log_q[2]), 16'h2002);
        chk("add_t3", 16'(log_q[3]), 16'h100A);
        chk("add_t4", 16'(log_q[4]), 16'h0208);
        chk("add_t5", 16'(log_q[5]), 16'h00A0);

        run_instr(8'h30, 1'b1, 1'b1, 1'b1, n);
        chk("sub_t5", 16'(log_q[5]), 16'h01A0);

        run_instr(8'h40, 1'b0, 1'b0, 1'b0, n);
        chk("sta_t4", 16'(log_q[4]), 16'h0044);
        chk("sta_cycles", 16'(n), EARLY ? 16'd5 : 16'd6);

        run_instr(8'h60, 1'b0, 1'b0, 1'b0, n);
        chk("jmp_t3", 16'(log_q[3]), 16'h4008);

        run_instr(8'h70, 1'b0, 1'b1, 1'b0, n);
        chk("jc_nt_t2", 16'(log_q[2]), 16'h1000);
        chk("jc_nt_cycles", 16'(n), EARLY ? 16'd3 : 16'd6);

        // Taken JC with cf dropping after T2: T3 must still load the PC.
        run_instr(8'h70, 1'b1, 1'b0, 1'b0, n);
        chk("jc_tk_t2", 16'(log_q[2]), 16'h2002);
        chk("jc_tk_t3", 16'(log_q[3]), 16'h4008);

        run_instr(8'h80, 1'b1, 1'b0, 1'b1, n);
        chk("jz_nt_t2", 16'(log_q[2]), 16'h1000);
        run_instr(8'h80, 1'b0, 1'b1, 1'b0, n);
        chk("jz_tk_t3", 16'(log_q[3]), 16'h4008);

        run_instr(8'hA5, 1'b0, 1'b0, 1'b0, n);
        chk("a5_cycles", 16'(n), EARLY ? 16'd2 : 16'd6);
        tail = '0;
        for (int k = 2; k < log_q.size(); k++) tail = tail | log_q[k];
        chk("a5_tail_zero", 16'(tail), 16'd0);

        // Program NOP, LDI, OUT.
        total = 0;
        run_instr(8'h00, 1'b0, 1'b0, 1'b0, n); total += n;
        run_instr(8'h55, 1'b0, 1'b0, 1'b0, n); total += n;
        chk("ldi_t3", 16'(log_q[3]), 16'h1028);
        run_instr(8'hE0, 1'b0, 1'b0, 1'b0, n); total += n;
        chk("out_t2", 16'(log_q[2]), 16'h0840);
        chk("prog_cycles", 16'(total), EARLY ? 16'd9 : 16'd18);

        // Reset dropped in the middle of ADD's T3.
        ireg = 8'h20;
        step_check(W_PCO | W_MAI, 3'd0, 1'b0);
        step_check(W_MO | W_II | W_PCS, 3'd1, 1'b0);
        step_check(W_PCO | W_MAI, 3'd2, 1'b0);
        chk_en = 1'b0;
        #2;
        chk("add_t3_live", 16'(ctrl), 16'h100A);
        rst = 1'b0;
        #1;
        chk("async_rst_tstate", 16'(tstate), 16'd0);
        chk("async_rst_ctrl", 16'(ctrl), 16'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_ctrl", 16'(ctrl), 16'd0);
        rst = 1'b1;
        run_instr(8'h20, 1'b0, 1'b0, 1'b0, n);
        chk("post_rst_t0", 16'(log_q[0]), 16'h2002);

        // HLT, then halt persists regardless of ireg until reset.
        ireg = 8'hF0;
        step_check(W_PCO | W_MAI, 3'd0, 1'b0);
        step_check(W_MO | W_II | W_PCS, 3'd1, 1'b0);
        step_check(W_HLT, 3'd2, 1'b0);
        chk("hlt_t2", 16'(last_ctrl), 16'h0001);
        for (int k = 0; k < 20; k++) begin
            if (k == 10) ireg = 8'h20;
            step_check(W_HLT, 3'd2, 1'b1);
        end
        chk_en = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("halt_rst_halted", 16'(halted), 16'd0);
        chk("halt_rst_tstate", 16'(tstate), 16'd0);
        chk("halt_rst_ctrl", 16'(ctrl), 16'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        run_instr(8'h00, 1'b0, 1'b0, 1'b0, n);

        chk_en = 1'b0;
        chk("tstate_max_lt6", 16'(max_t < 3'd6), 16'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/microcode_sequencer.md
MICROCODE_SEQUENCER -- requirements
Module: microcode_sequencer

Interface
REQ-001 Parameter CONTROL_SIGNALS, default 15, SHALL set the control word width; bit order: 0 HLT, 1 MAI, 2 MI, 3 MO, 4 II, 5 AI, 6 AO, 7 ALO, 8 ALS, 9 BI, 10 BO, 11 OUI, 12 PCS, 13 PCO, 14 PCI.
REQ-002 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1: reset, asynchronous, active-low.
REQ-004 Port ireg, input, 8: instruction register contents; the opcode is ireg[7:4] and ireg[3:0] is ignored.
REQ-005 Port zf, input, 1: ALU zero flag.
REQ-006 Port cf, input, 1: ALU carry flag.
REQ-007 Port ctrl, output, CONTROL_SIGNALS: control word for the current T-state, combinational from state, ireg and flags.
REQ-008 Port tstate, output, 3: current microstep T0..T5, encoded 0..5.
REQ-009 Port halted, output, 1: high while the sequencer is in HALT.

Function
REQ-010 States SHALL be RUN (tstate steps) and HALT; tstate SHALL never hold values 6 or 7.
REQ-011 Fetch, all opcodes: T0 = PCO|MAI; T1 = MO|II|PCS.
REQ-012 Opcode decoding from T2 onward; instructions are 2 bytes, with the operand fetched via PC:
- 0 NOP: no steps.
- 1 LDA: T2 PCO|MAI; T3 MO|MAI|PCS; T4 MO|AI.
- 2 ADD: T2 PCO|MAI; T3 MO|MAI|PCS; T4 MO|BI; T5 ALO|AI.
- 3 SUB: as ADD, with T5 = ALO|ALS|AI.
- 4 STA: T2 PCO|MAI; T3 MO|MAI|PCS; T4 AO|MI.
- 5 LDI: T2 PCO|MAI; T3 MO|AI|PCS.
- 6 JMP: T2 PCO|MAI; T3 MO|PCI.
- 7 JC / 8 JZ: when cf/zf is high at T2, behave as JMP; otherwise T2 = PCS only (skip operand).
- 14 OUT: T2 AO|OUI.
- 15 HLT: T2 HLT.
- 9..13: NOP.
REQ-013 JC/JZ flag SHALL be sampled into a taken bit on the clk edge ending T2 (the T2 decision uses the live flag); T3 SHALL use the stored bit so that flag changes after T2 have no effect.
REQ-014 On the edge ending the T2 step of HLT, the state SHALL go to HALT; in HALT, ctrl = HLT only, halted = 1 and tstate = 2, held until reset.
REQ-015 Unused steps SHALL output ctrl = 0.
REQ-016 At most one bus driver (MO, AO, ALO, PCO) SHALL be active in any step.
REQ-017 After T5, tstate SHALL wrap to T0.

Reset
REQ-018 While rst = 0: tstate = 0, taken bit = 0, halted = 0, ctrl = all-zero (forced, overriding decode).
REQ-019 Reset asserted mid-instruction or in HALT SHALL take effect immediately, without a clock edge.
REQ-020 The first rising edge after rst deasserts SHALL complete T0 (PCO|MAI was visible during T0).

Configuration
REQ-021 Macro SEQ_EARLY_END_EN.
- Defined: after an instruction's last non-empty step, the next state SHALL be T0. Cycle counts: NOP 2, LDA 5, ADD/SUB 6, STA 5, LDI 4, JMP 4, JC/JZ not taken 3, OUT 3.
- Undefined: every instruction SHALL take 6 cycles T0..T5, with empty steps ctrl = 0.
- HLT SHALL be identical in both builds.

Verification
REQ-022 Reset low mid-T3 of ADD -> tstate = 0 and ctrl = 0 asynchronously; after release, T0 ctrl = PCO|MAI (0x2002).
REQ-023 ireg = 0x20, clock through T0..T5 -> ctrl sequence 0x2002, 0x1018, 0x2002, 0x100A, 0x0208, 0x00A0.
REQ-024 ireg = 0x70, cf = 0 -> T2 ctrl = 0x1000 then T0 (with SEQ_EARLY_END_EN); with cf = 1 -> T2 0x2002, T3 0x4008, and cf dropping in T3 does not change T3.
REQ-025 ireg = 0xF0 -> T2 ctrl = 0x0001, then halted = 1 persists for 20 cycles; rst pulse clears it.
REQ-026 Program NOP, LDI, OUT with SEQ_EARLY_END_EN defined vs undefined -> totals of 9 vs 18 cycles; tstate never reaches 6.
REQ-027 ireg = 0xA5 -> behaves as NOP; 2 cycles when defined, 6 when undefined, with ctrl = 0 from T2 on.
